// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared register-file sizing constants and address/data types.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int NREG_DEFAULT  = 32;
  localparam int WIDTH_DEFAULT = 64;
  localparam int ZERO_REG      = NREG_DEFAULT - 1;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [63:0] reg_data_t;

endpackage

`default_nettype wire

// File: rtl/decoder_n.sv
// ============================================================================
// Module : decoder_n
// Brief  : Combinational AW-bit to N-line one-hot decoder with enable.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_n #(
  parameter int N  = 32,
  parameter int AW = $clog2(N)
) (
  input  logic [AW-1:0] sel,
  input  logic          en,
  output logic [N-1:0]  onehot
);

  for (genvar i = 0; i < N; i++) begin : g_line
    assign onehot[i] = en && (sel == AW'(i));
  end

endmodule

`default_nettype wire

// File: rtl/reg_write_demux.sv
// ============================================================================
// Module : reg_write_demux
// Brief  : Register-file write side: capture stage, one-hot decode, commit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_write_demux
  import regfile_pkg::*;
#(
  parameter  int NREG  = NREG_DEFAULT,
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [NREG*WIDTH-1:0] regs_q,
  output logic [NREG-1:0]       wr_onehot,
  output logic                  pend_valid,
  output logic [AW-1:0]         pend_addr,
  output logic [WIDTH-1:0]      pend_data
);

  localparam logic [AW-1:0] c_zero_addr = AW'(NREG - 1);

  logic             r_pend_valid;
  logic [AW-1:0]    r_pend_addr;
  logic [WIDTH-1:0] r_pend_data;
  logic             w_capture;
  logic [NREG-1:0]  w_onehot;

  // Writes to the zero register are dropped here so they never reach decode.
  assign w_capture = wr_en && (wr_addr != c_zero_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
    end else begin
      r_pend_valid <= w_capture;
      if (w_capture) begin
        r_pend_addr <= wr_addr;
        r_pend_data <= wr_data;
      end
    end
  end

  decoder_n #(
    .N  (NREG),
    .AW (AW)
  ) u_commit_dec (
    .sel    (r_pend_addr),
    .en     (r_pend_valid),
    .onehot (w_onehot)
  );

  for (genvar i = 0; i < NREG - 1; i++) begin : g_reg
    logic [WIDTH-1:0] r_word;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_word <= '0;
      end else if (w_onehot[i]) begin
        r_word <= r_pend_data;
      end
    end

    assign regs_q[i*WIDTH +: WIDTH] = r_word;
  end

  assign regs_q[(NREG-1)*WIDTH +: WIDTH] = '0;

  assign wr_onehot  = w_onehot;
  assign pend_valid = r_pend_valid;
  assign pend_addr  = r_pend_addr;
  assign pend_data  = r_pend_data;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_demux.sv
// ============================================================================
// Module : tb_reg_write_demux
// Brief  : Scoreboard bench for reg_write_demux against an array model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_write_demux;

  localparam int NREG  = 32;
  localparam int WIDTH = 64;
  localparam int AW    = 5;

  logic                  clk;
  logic                  reset;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic [NREG*WIDTH-1:0] regs_q;
  logic [NREG-1:0]       wr_onehot;
  logic                  pend_valid;
  logic [AW-1:0]         pend_addr;
  logic [WIDTH-1:0]      pend_data;

  reg_write_demux #(.NREG(NREG), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .regs_q     (regs_q),
    .wr_onehot  (wr_onehot),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr),
    .pend_data  (pend_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREG*WIDTH-1:0] regs;
    logic                  pv;
    logic [AW-1:0]         pa;
    logic [WIDTH-1:0]      pd;
    logic [NREG-1:0]       oh;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: architectural contents plus the one write still in flight.
  logic [WIDTH-1:0] mem [NREG];
  logic             m_pv;
  logic [AW-1:0]    m_pa;
  logic [WIDTH-1:0] m_pd;

  task automatic drive(input logic r, input logic e, input logic [AW-1:0] a,
                       input logic [WIDTH-1:0] d);
    exp_t x;
    reset = r; wr_en = e; wr_addr = a; wr_data = d;
    if (r) begin
      for (int i = 0; i < NREG; i++) mem[i] = '0;
      m_pv = 1'b0; m_pa = '0; m_pd = '0;
    end else begin
      if (m_pv) mem[m_pa] = m_pd;
      m_pv = e && (int'(a) != NREG - 1);
      if (m_pv) begin
        m_pa = a;
        m_pd = d;
      end
    end
    for (int i = 0; i < NREG; i++) x.regs[i*WIDTH +: WIDTH] = mem[i];
    x.pv = m_pv;
    x.pa = m_pa;
    x.pd = m_pd;
    x.oh = m_pv ? (NREG'(1) << m_pa) : '0;
    @(posedge clk);
    q.push_back(x);
    #1;
  endtask

  // Monitor: compares the DUT state after each edge against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < NREG; i++) begin
          checks++;
          if (regs_q[i*WIDTH +: WIDTH] !== e.regs[i*WIDTH +: WIDTH]) begin
            errors++;
            $display("FAIL regs_q word %0d at %0t: got %h expected %h", i, $time,
                     regs_q[i*WIDTH +: WIDTH], e.regs[i*WIDTH +: WIDTH]);
          end
        end
        checks++;
        if (pend_valid !== e.pv) begin
          errors++;
          $display("FAIL pend_valid at %0t: got %b expected %b", $time, pend_valid, e.pv);
        end
        if (e.pv) begin
          checks++;
          if (pend_addr !== e.pa || pend_data !== e.pd) begin
            errors++;
            $display("FAIL pend_addr/data at %0t: got %0d/%h expected %0d/%h", $time,
                     pend_addr, pend_data, e.pa, e.pd);
          end
        end
        checks++;
        if (wr_onehot !== e.oh) begin
          errors++;
          $display("FAIL wr_onehot at %0t: got %h expected %h", $time, wr_onehot, e.oh);
        end
        checks++;
        if ($countones(wr_onehot) > 1 || wr_onehot[NREG-1] !== 1'b0) begin
          errors++;
          $display("FAIL onehot_legal at %0t: got %h required at most one bit, bit %0d clear",
                   $time, wr_onehot, NREG - 1);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    m_pv = 1'b0; m_pa = '0; m_pd = '0;
    for (int i = 0; i < NREG; i++) mem[i] = '0;

    // Reset, then a single write that must appear after two edges.
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 1, 5, 64'hDEAD_BEEF_0000_0001);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Write to the zero register is discarded.
    drive(0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Back-to-back, including same address.
    drive(0, 1, 3, 64'h11);
    drive(0, 1, 3, 64'h22);
    drive(0, 1, 7, 64'h33);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Reset while a write is pending drops it.
    drive(0, 1, 9, 64'hAB);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Random stream.
    for (int n = 0; n < 1000; n++) begin
      drive(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)),
            {$urandom, $urandom});
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
